// File: rtl/keypad_entry_pkg.sv
// keypad_entry_pkg: key codes, FSM states, limits and saturation helper shared by keypad_entry
package keypad_entry_pkg;
  localparam logic [3:0] KEY_SIGN = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hC;
  localparam int NDIGITS = 4;
  localparam logic [13:0] MAX_POS = 14'd8191;
  localparam logic [13:0] MAX_NEG_MAG = 14'd8192;
  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_CONVERT, S_FINISH} state_t;
  // returns {ovf, value}; negative zero comes out as plain zero because 0 - 0 = 0
  function automatic logic [14:0] saturate(input logic neg, input logic [13:0] mag);
    return neg ? (mag > MAX_NEG_MAG ? {1'b1, 14'd0 - MAX_NEG_MAG} : {1'b0, 14'd0 - mag})
               : (mag > MAX_POS ? {1'b1, MAX_POS} : {1'b0, mag});
  endfunction
endpackage

// File: rtl/keypad_entry_if.sv
// keypad_entry_if: key strobe input and result/echo outputs of the keypad entry block
interface keypad_entry_if;
  logic key_valid;
  logic [3:0] key_code;
  logic [13:0] value;
  logic value_valid;
  logic ovf;
  logic busy;
  logic sig;
  logic [3:0] bcd3;
  logic [3:0] bcd2;
  logic [3:0] bcd1;
  logic [3:0] bcd0;
  modport master(output key_valid, key_code,
                 input value, value_valid, ovf, busy, sig, bcd3, bcd2, bcd1, bcd0);
  modport slave(input key_valid, key_code,
                output value, value_valid, ovf, busy, sig, bcd3, bcd2, bcd1, bcd0);
endinterface

// File: rtl/keypad_entry_bcd_to_bin.sv
// bcd_to_bin: 4-cycle Horner BCD-to-binary converter, msd first; o_done/o_mag are valid in the last step
module bcd_to_bin
  import keypad_entry_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [15:0] i_dig,
  output logic        o_done,
  output logic [13:0] o_mag
);
  logic r_run;
  logic [1:0] r_idx;
  logic [13:0] r_acc;
  logic [15:0] w_sh;
  logic [13:0] w_next;
  assign w_sh = i_dig << {r_idx, 2'b00};
  assign w_next = r_acc * 14'd10 + {10'd0, w_sh[15:12]};
  assign o_done = r_run && r_idx == 2'(NDIGITS - 1);
  assign o_mag = w_next;
  // one digit per cycle; the final sum is exposed combinationally so the caller can register it on done
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_run <= 1'b0;
      r_idx <= '0;
      r_acc <= '0;
    end else if (i_start) begin
      r_run <= 1'b1;
      r_idx <= '0;
      r_acc <= '0;
    end else if (r_run) begin
      r_acc <= w_next;
      r_idx <= r_idx + 2'd1;
      r_run <= !o_done;
    end
endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: signed 4-digit keypad entry with BCD echo and saturated 14-bit result; ENTRY_TIMEOUT_EN adds idle auto-clear
module keypad_entry
  import keypad_entry_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input logic clk,
  input logic rst_n,
  keypad_entry_if.slave bus
);
  state_t r_state;
  logic [15:0] r_dig;
  logic [2:0] r_cnt;
  logic r_sig;
  logic r_busy;
  logic r_valid;
  logic r_ovf;
  logic [13:0] r_value;
  logic w_key;
  logic w_acc;
  logic w_start;
  logic w_done;
  logic w_tmo;
  logic [13:0] w_mag;
  logic [14:0] w_sat;
  assign w_key = bus.key_valid && (r_state == S_IDLE || r_state == S_ENTRY);
  assign w_acc = w_key && bus.key_code <= KEY_ENTER;
  assign w_start = w_key && bus.key_code == KEY_ENTER;
  assign w_sat = saturate(r_sig, w_mag);
  assign bus.value = r_value;
  assign bus.value_valid = r_valid;
  assign bus.ovf = r_ovf;
  assign bus.busy = r_busy;
  assign bus.sig = r_sig;
  assign {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0} = r_dig;

  bcd_to_bin u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_dig   (r_dig),
    .o_done  (w_done),
    .o_mag   (w_mag)
  );

`ifdef ENTRY_TIMEOUT_EN
  logic [31:0] r_tmo;
  logic w_elig;
  assign w_elig = r_state == S_ENTRY || (r_state == S_IDLE && r_sig);
  assign w_tmo = w_elig && !w_acc && r_tmo == TIMEOUT_CYCLES - 1;
  // idle counter: restarts on accepted keys, holds while converting, wraps when it fires the clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_tmo <= '0;
    else if (!r_busy) r_tmo <= (w_acc || !w_elig || w_tmo) ? '0 : r_tmo + 32'd1;
`else
  localparam int unsigned unused_tmo = TIMEOUT_CYCLES;
  assign w_tmo = 1'b0;
`endif

  // entry FSM: digit shift register, sign, conversion sequencing and saturated result registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_dig <= '0;
      r_cnt <= '0;
      r_sig <= 1'b0;
      r_busy <= 1'b0;
      r_valid <= 1'b0;
      r_ovf <= 1'b0;
      r_value <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_ENTRY:
          if (w_key && bus.key_code <= 4'd9) begin
            if (r_cnt < 3'(NDIGITS)) begin
              r_dig <= {r_dig[11:0], bus.key_code};
              r_cnt <= r_cnt + 3'd1;
              r_state <= S_ENTRY;
            end
          end else if (w_key && bus.key_code == KEY_SIGN) r_sig <= !r_sig;
          else if ((w_key && bus.key_code == KEY_CLEAR) || w_tmo) begin
            r_dig <= '0;
            r_cnt <= '0;
            r_sig <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_start) begin
            r_busy <= 1'b1;
            r_state <= S_CONVERT;
          end
        S_CONVERT:
          if (w_done) begin
            {r_ovf, r_value} <= w_sat;
            r_valid <= 1'b1;
            r_state <= S_FINISH;
          end
        default: begin
          r_dig <= '0;
          r_cnt <= '0;
          r_sig <= 1'b0;
          r_busy <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: directed table-driven bench for keypad_entry; covers ENTRY_TIMEOUT_EN when that macro is defined
module tb_keypad_entry;
  import keypad_entry_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  int n_pulse = 0;
  int n_enter = 0;
  keypad_entry_if bus ();
  keypad_entry #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = !clk;
  always @(negedge clk) if (bus.value_valid) n_pulse++;

  typedef struct {
    logic [3:0]  code;
    logic        sig;
    logic [15:0] dig;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] echo();
    return {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
  endfunction

  task automatic key(input logic [3:0] code);
    bus.key_valid = 1'b1;
    bus.key_code = code;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    bus.key_code = 4'h0;
  endtask

  task automatic keys(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    key(a);
    key(b);
    key(c);
    key(d);
  endtask

  task automatic enter_check(input string nm, input logic [13:0] ev, input logic eo);
    int pulses = 0;
    key(KEY_ENTER);
    chk({nm, " busy@N+1"}, 32'(bus.busy), 32'd1);
    pulses += int'(bus.value_valid);
    for (int i = 2; i <= 5; i++) begin
      @(posedge clk);
      #1;
      pulses += int'(bus.value_valid);
    end
    chk({nm, " value@N+5"}, 32'(bus.value), 32'(ev));
    chk({nm, " ovf@N+5"}, 32'(bus.ovf), 32'(eo));
    chk({nm, " valid@N+5"}, 32'(bus.value_valid), 32'd1);
    chk({nm, " busy@N+5"}, 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    pulses += int'(bus.value_valid);
    chk({nm, " busy@N+6"}, 32'(bus.busy), 32'd0);
    chk({nm, " echo@N+6"}, 32'({bus.sig, echo()}), 32'd0);
    chk({nm, " pulses"}, 32'(pulses), 32'd1);
    n_enter++;
  endtask

  initial begin
    bus.key_valid = 1'b0;
    bus.key_code = 4'h0;
    tbl[0]  = '{4'h1, 1'b0, 16'h0001};
    tbl[1]  = '{4'h2, 1'b0, 16'h0012};
    tbl[2]  = '{4'h3, 1'b0, 16'h0123};
    tbl[3]  = '{4'h4, 1'b0, 16'h1234};
    tbl[4]  = '{4'h5, 1'b0, 16'h1234};
    tbl[5]  = '{KEY_SIGN, 1'b1, 16'h1234};
    tbl[6]  = '{4'hD, 1'b1, 16'h1234};
    tbl[7]  = '{KEY_SIGN, 1'b0, 16'h1234};
    tbl[8]  = '{KEY_CLEAR, 1'b0, 16'h0000};
    tbl[9]  = '{KEY_SIGN, 1'b1, 16'h0000};
    tbl[10] = '{4'h9, 1'b1, 16'h0009};
    tbl[11] = '{KEY_CLEAR, 1'b0, 16'h0000};
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {bus.value, bus.value_valid, bus.ovf, bus.busy, bus.sig}, 32'd0);
    chk("reset echo", 32'(echo()), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      key(tbl[i].code);
      chk($sformatf("vec%0d sig", i), 32'(bus.sig), 32'(tbl[i].sig));
      chk($sformatf("vec%0d echo", i), 32'(echo()), 32'(tbl[i].dig));
    end
    enter_check("empty", 14'd0, 1'b0);
    keys(4'h1, 4'h2, 4'h3, 4'h4);
    enter_check("1234", 14'd1234, 1'b0);
    key(KEY_SIGN);
    keys(4'h8, 4'h1, 4'h9, 4'h2);
    enter_check("-8192", 14'h2000, 1'b0);
    keys(4'h9, 4'h9, 4'h9, 4'h9);
    enter_check("9999", 14'd8191, 1'b1);
    key(KEY_SIGN);
    keys(4'h9, 4'h9, 4'h9, 4'h9);
    enter_check("-9999", 14'h2000, 1'b1);
    keys(4'h8, 4'h1, 4'h9, 4'h1);
    enter_check("8191", 14'd8191, 1'b0);
    keys(4'h8, 4'h1, 4'h9, 4'h2);
    enter_check("8192", 14'd8191, 1'b1);
    key(KEY_SIGN);
    keys(4'h8, 4'h1, 4'h9, 4'h3);
    enter_check("-8193", 14'h2000, 1'b1);
    key(KEY_SIGN);
    keys(4'h1, 4'h2, 4'h3, 4'h4);
    enter_check("-1234", 14'h3B2E, 1'b0);
    key(KEY_SIGN);
    enter_check("-0", 14'd0, 1'b0);
    key(4'h7);
    key(KEY_ENTER);
    key(4'h3);
    key(KEY_CLEAR);
    chk("drop echo@N+3", 32'(echo()), 32'h0007);
    chk("drop busy@N+3", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("drop value@N+5", 32'(bus.value), 32'd7);
    chk("drop valid@N+5", 32'(bus.value_valid), 32'd1);
    n_enter++;
    @(posedge clk);
    #1;
    chk("drop echo@N+6", 32'({bus.sig, echo()}), 32'd0);
    key(4'h5);
    key(4'h6);
    key(KEY_ENTER);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort outputs", {bus.value, bus.value_valid, bus.ovf, bus.busy, bus.sig}, 32'd0);
    chk("abort echo", 32'(echo()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("abort no busy", 32'(bus.busy), 32'd0);
    key(4'h4);
    key(4'h2);
    enter_check("42", 14'd42, 1'b0);
`ifdef ENTRY_TIMEOUT_EN
    key(KEY_SIGN);
    key(4'h3);
    repeat (15) @(posedge clk);
    #1;
    chk("tmo hold echo", 32'({bus.sig, echo()}), 32'h10003);
    @(posedge clk);
    #1;
    chk("tmo clear echo", 32'({bus.sig, echo()}), 32'd0);
    repeat (20) @(posedge clk);
    #1;
`endif
    chk("total valid pulses", 32'(n_pulse), 32'(n_enter));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
